// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master's command port among N_REQ requesters.
// Launches one transfer per grant, watches the bus for completion and aborts hung transfers.
module apb_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_write,
  input  logic [N_REQ*32-1:0]  req_addr,
  input  logic [N_REQ*32-1:0]  req_wdata,
  input  logic [N_REQ*4-1:0]   req_strb,
  output logic [N_REQ-1:0]     req_done,
  output logic                 req_err,
  output logic [31:0]          req_rdata,
  output logic [N_REQ-1:0]     grant,
  output logic                 SWRITE,
  output logic [31:0]          SADDR,
  output logic [31:0]          SWDATA,
  output logic [3:0]           SSTRB,
  output logic                 transfer,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PREADY,
  input  logic                 PSLVERR,
  input  logic [31:0]          PRDATA
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [IW-1:0]     gnt_idx_q;
  logic [CW-1:0]     cnt_q;
  logic [N_REQ-1:0]  grant_q;
  logic [N_REQ-1:0]  req_done_q;
  logic              req_err_q;
  logic [31:0]       req_rdata_q;
  logic              swrite_q;
  logic [31:0]       saddr_q;
  logic [31:0]       swdata_q;
  logic [3:0]        sstrb_q;
  logic              transfer_q;

  logic [31:0]       addr_arr  [N_REQ];
  logic [31:0]       wdata_arr [N_REQ];
  logic [3:0]        strb_arr  [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[32*gi +: 32];
      assign wdata_arr[gi] = req_wdata[32*gi +: 32];
      assign strb_arr[gi]  = req_strb[4*gi +: 4];
    end
  endgenerate

  // Scan starts just past the last owner so every requester gets a turn.
  logic          arb_found;
  logic [IW-1:0] arb_idx;
  logic [IW-1:0] cand;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = IW'((int'(rr_ptr_q) + off) % N_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  wire bus_done = PSEL & PENABLE & PREADY;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IW'(N_REQ - 1);
      gnt_idx_q   <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      req_done_q  <= '0;
      req_err_q   <= 1'b0;
      req_rdata_q <= '0;
      swrite_q    <= 1'b0;
      saddr_q     <= '0;
      swdata_q    <= '0;
      sstrb_q     <= '0;
      transfer_q  <= 1'b0;
    end else begin
      transfer_q <= 1'b0;
      req_done_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            grant_q    <= N_REQ'(1) << arb_idx;
            gnt_idx_q  <= arb_idx;
            swrite_q   <= req_write[arb_idx];
            saddr_q    <= addr_arr[arb_idx];
            swdata_q   <= wdata_arr[arb_idx];
            sstrb_q    <= strb_arr[arb_idx];
            transfer_q <= 1'b1;
            state_q    <= ISSUE;
          end else begin
            grant_q <= '0;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus_done) begin
            req_rdata_q <= swrite_q ? 32'h0 : PRDATA;
            req_err_q   <= PSLVERR;
            req_done_q  <= grant_q;
            state_q     <= DONE;
          end else if (cnt_q == CW'(TIMEOUT - 2)) begin
            // Last WAIT cycle: DONE lands exactly TIMEOUT cycles after ISSUE.
            req_rdata_q <= '0;
            req_err_q   <= 1'b1;
            req_done_q  <= grant_q;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          rr_ptr_q <= gnt_idx_q;
          grant_q  <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_done  = req_done_q;
  assign req_err   = req_err_q;
  assign req_rdata = req_rdata_q;
  assign grant     = grant_q;
  assign SWRITE    = swrite_q;
  assign SADDR     = saddr_q;
  assign SWDATA    = swdata_q;
  assign SSTRB     = sstrb_q;
  assign transfer  = transfer_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: requester agents, a small APB bus/slave model, and checks.
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            PCLK;
  logic            PRESET;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N*4-1:0]  req_strb;
  logic [N-1:0]    req_done;
  logic            req_err;
  logic [31:0]     req_rdata;
  logic [N-1:0]    grant;
  logic            SWRITE;
  logic [31:0]     SADDR;
  logic [31:0]     SWDATA;
  logic [3:0]      SSTRB;
  logic            transfer;
  logic            PSEL, PENABLE, PREADY, PSLVERR;
  logic [31:0]     PRDATA;

  apb_req_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata), .grant(grant),
    .SWRITE(SWRITE), .SADDR(SADDR), .SWDATA(SWDATA), .SSTRB(SSTRB), .transfer(transfer),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Commands posted by the main sequence; a requester is valid while posts exceed completions.
  int          post_cnt [N];
  int          done_cnt [N];
  bit          cmd_write [N];
  logic [31:0] cmd_addr  [N];
  logic [31:0] cmd_wdata [N];
  logic [3:0]  cmd_strb  [N];
  bit          hang;
  bit          stray;

  // Observation logs
  int          done_tot;
  int          xfer_cnt;
  int          d_idx[$];
  int          d_err[$];
  logic [31:0] d_rdata[$];
  int          d_cyc[$];
  int          g_idx[$];
  logic [31:0] g_addr[$];
  int          g_write[$];
  logic [3:0]  g_strb[$];
  int          g_cyc[$];

  logic [31:0] mem [logic [31:0]];

  int tot;
  int bad;

  function automatic int oh_idx(input logic [N-1:0] g);
    int n;
    int r;
    n = 0;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) begin n++; r = i; end
    return (n == 1) ? r : -1;
  endfunction

  // Requester agents, bus master/slave model and monitor, stepped #1 after each rising edge.
  initial begin : monitor
    int          cyc;
    int          phase;
    logic        b_write;
    logic [31:0] b_addr, b_wdata, b_old;
    logic [3:0]  b_strb;
    cyc = 0; phase = 0; done_tot = 0; xfer_cnt = 0;
    b_write = 0; b_addr = 0; b_wdata = 0; b_strb = 0; b_old = 0;
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = '0;
    forever begin
      @(posedge PCLK);
      #1;
      cyc++;
      if (req_done != '0) begin
        for (int i = 0; i < N; i++) begin
          if (req_done[i]) begin
            done_cnt[i]++;
            done_tot++;
            d_idx.push_back(i);
            d_err.push_back(int'(req_err));
            d_rdata.push_back(req_rdata);
            d_cyc.push_back(cyc);
          end
        end
        phase = 0;
      end
      if (transfer) begin
        xfer_cnt++;
        g_idx.push_back(oh_idx(grant));
        g_addr.push_back(SADDR);
        g_write.push_back(int'(SWRITE));
        g_strb.push_back(SSTRB);
        g_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) begin
        req_valid[i]           = (post_cnt[i] != done_cnt[i]);
        req_write[i]           = cmd_write[i];
        req_addr[32*i +: 32]   = cmd_addr[i];
        req_wdata[32*i +: 32]  = cmd_wdata[i];
        req_strb[4*i +: 4]     = cmd_strb[i];
      end
      PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = '0;
      if (PRESET) begin
        phase = 0;
      end else if (transfer) begin
        b_write = SWRITE; b_addr = SADDR; b_wdata = SWDATA; b_strb = SSTRB;
        phase = 1;
        if (stray) begin
          PSEL = 1; PENABLE = 1; PREADY = 1; PSLVERR = 1; PRDATA = 32'hDEADBEEF;
        end
      end else if (phase == 1) begin
        PSEL = 1;
        phase = 2;
      end else if (phase == 2) begin
        PSEL = 1; PENABLE = 1;
        if (!hang) begin
          PREADY  = 1;
          PSLVERR = (b_addr == 32'h20);
          b_old   = mem.exists(b_addr) ? mem[b_addr] : 32'h0;
          if (b_write) begin
            if (!PSLVERR) begin
              for (int b = 0; b < 4; b++) if (b_strb[b]) b_old[8*b +: 8] = b_wdata[8*b +: 8];
              mem[b_addr] = b_old;
            end
          end else begin
            PRDATA = b_old;
          end
          phase = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic post(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    cmd_write[i] = wr; cmd_addr[i] = a; cmd_wdata[i] = d; cmd_strb[i] = s;
    post_cnt[i]++;
  endtask

  task automatic wait_dones(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (done_tot < target && k < budget) begin
      @(negedge PCLK);
      k++;
    end
    tot++;
    if (done_tot < target) begin
      bad++;
      $display("FAIL %s: completions got %0d expected %0d", nm, done_tot, target);
    end
  endtask

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          stray;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int base;
    int x0;
    int dt;
    tot = 0; bad = 0; hang = 0; stray = 0;
    for (int i = 0; i < N; i++) begin
      post_cnt[i] = 0; cmd_write[i] = 0; cmd_addr[i] = 0; cmd_wdata[i] = 0; cmd_strb[i] = 0;
    end
    vecs[0] = '{1, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{2, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 1'b0, 32'hA5A5A5A5};
    vecs[2] = '{0, 1'b1, 32'h20, 32'h11111111, 4'hF, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{3, 1'b1, 32'h14, 32'h12345678, 4'h3, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{0, 1'b0, 32'h14, 32'h0,        4'h0, 1'b1, 1'b0, 32'h00005678};
    vecs[5] = '{1, 1'b1, 32'h14, 32'hAABBCCDD, 4'hC, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{2, 1'b0, 32'h14, 32'h0,        4'h0, 1'b0, 1'b0, 32'hAABB5678};
    vecs[7] = '{3, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 1'b0, 32'hA5A5A5A5};

    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(req_done), 32'h0);
    chk("rst_transfer", 32'(transfer), 32'h0);
    chk("rst_err", 32'(req_err), 32'h0);
    chk("rst_rdata", req_rdata, 32'h0);
    chk("rst_saddr", SADDR, 32'h0);
    chk("rst_swdata", SWDATA, 32'h0);
    chk("rst_swrite_sstrb", {27'h0, SWRITE, SSTRB}, 32'h0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Contention from reset: requester 0 stays valid for a second grant.
    base = g_idx.size();
    x0 = xfer_cnt;
    for (int i = 0; i < N; i++) post(i, 1'b1, 32'h40 + 32'(4*i), 32'h100 + 32'(i), 4'hF);
    post_cnt[0]++;
    wait_dones(5, 200, "contention");
    chk("cont_xfers", 32'(xfer_cnt - x0), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (base + k < g_idx.size()) chk($sformatf("cont_grant%0d", k), 32'(g_idx[base+k]), 32'(k % N));
      else chk($sformatf("cont_grant%0d", k), 32'hFFFFFFFF, 32'(k % N));
    end
    if (base + 1 < g_cyc.size()) chk("cont_gap", 32'(g_cyc[base+1] - g_cyc[base]), 32'd5);
    else chk("cont_gap", 32'hFFFFFFFF, 32'd5);
    repeat (2) @(negedge PCLK);

    for (int v = 0; v < 8; v++) begin
      base = done_tot;
      stray = vecs[v].stray;
      post(vecs[v].idx, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb);
      wait_dones(base + 1, 100, $sformatf("v%0d_wait", v));
      stray = 0;
      if (d_idx.size() > 0 && g_idx.size() > 0) begin
        dt = d_cyc[d_cyc.size()-1] - g_cyc[g_cyc.size()-1];
        $display("vec %0d: req=%0d wr=%0d addr=%h err=%0d rdata=%h lat=%0d", v, vecs[v].idx,
                 vecs[v].wr, vecs[v].addr, d_err[d_err.size()-1], d_rdata[d_rdata.size()-1], dt);
        chk($sformatf("v%0d_grant", v), 32'(g_idx[g_idx.size()-1]), 32'(vecs[v].idx));
        chk($sformatf("v%0d_saddr", v), g_addr[g_addr.size()-1], vecs[v].addr);
        chk($sformatf("v%0d_swrite", v), 32'(g_write[g_write.size()-1]), 32'(vecs[v].wr));
        chk($sformatf("v%0d_done_idx", v), 32'(d_idx[d_idx.size()-1]), 32'(vecs[v].idx));
        chk($sformatf("v%0d_err", v), 32'(d_err[d_err.size()-1]), 32'(vecs[v].exp_err));
        chk($sformatf("v%0d_rdata", v), d_rdata[d_rdata.size()-1], vecs[v].exp_rdata);
        chk($sformatf("v%0d_latency", v), 32'(dt), 32'd3);
      end
      @(negedge PCLK);
    end

    // Timeout: slave never answers.
    hang = 1;
    base = done_tot;
    post(2, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_dones(base + 1, 100, "to_wait");
    hang = 0;
    if (d_idx.size() > 0) begin
      dt = d_cyc[d_cyc.size()-1] - g_cyc[g_cyc.size()-1];
      $display("timeout: req=%0d err=%0d rdata=%h lat=%0d", d_idx[d_idx.size()-1],
               d_err[d_err.size()-1], d_rdata[d_rdata.size()-1], dt);
      chk("to_idx", 32'(d_idx[d_idx.size()-1]), 32'd2);
      chk("to_err", 32'(d_err[d_err.size()-1]), 32'd1);
      chk("to_rdata", d_rdata[d_rdata.size()-1], 32'h0);
      chk("to_latency", 32'(dt), 32'(TO));
    end
    repeat (2) @(negedge PCLK);
    chk("to_idle_grant", 32'(grant), 32'h0);
    chk("to_idle_transfer", 32'(transfer), 32'h0);

    // Reset while waiting on the bus.
    x0 = xfer_cnt;
    post(1, 1'b0, 32'h10, 32'h0, 4'h0);
    dt = 0;
    while (xfer_cnt == x0 && dt < 50) begin
      @(negedge PCLK);
      dt++;
    end
    chk("rw_issue_seen", 32'(xfer_cnt - x0), 32'd1);
    post(0, 1'b0, 32'h14, 32'h0, 4'h0);
    post(3, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge PCLK);
    base = done_tot;
    PRESET = 1'b1;
    #1;
    chk("rw_grant", 32'(grant), 32'h0);
    chk("rw_saddr", SADDR, 32'h0);
    chk("rw_err", 32'(req_err), 32'h0);
    chk("rw_done", 32'(req_done), 32'h0);
    repeat (3) @(negedge PCLK);
    chk("rw_no_done", 32'(done_tot - base), 32'd0);
    PRESET = 1'b0;
    wait_dones(base + 3, 200, "rw_wait");
    if (d_idx.size() >= base + 3) begin
      $display("after reset: order %0d %0d %0d", d_idx[base], d_idx[base+1], d_idx[base+2]);
      chk("rw_order0", 32'(d_idx[base]), 32'd0);
      chk("rw_order1", 32'(d_idx[base+1]), 32'd1);
      chk("rw_order2", 32'(d_idx[base+2]), 32'd3);
      chk("rw_rdata1", d_rdata[base+1], 32'hA5A5A5A5);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
